// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch side, the data side, the shared memory and mem_arbiter.
// slave is the arbiter's view; master is the view of the surrounding pipeline/memory.
interface mem_arbiter_if;
  logic        hlt;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_rdy;
  logic [15:0] i_rdata;
  logic        d_re;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_rdy;
  logic [15:0] d_rdata;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  modport slave (
    input  hlt, i_req, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdy, i_rdata, d_rdy, d_rdata, mem_re, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output hlt, i_req, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdy, i_rdata, d_rdy, d_rdata, mem_re, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one single-ported memory with fixed read latency LAT.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data always beats instruction.
//
// state | meaning
// IDLE  | sample requests, grant and latch owner/type/addr/wdata
// ISSUE | one-cycle mem_re/mem_we strobe
// WAIT  | LAT cycles, counter down to 0, read data captured on last edge
// RESP  | owner's rdy pulse, requests ignored
module mem_arbiter #(
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        grant, capture;
  logic        d_any, i_any, pick_d;
  logic        owner_d, is_wr;
  logic [15:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;

  assign d_any = bus.d_re | bus.d_we;
  assign i_any = bus.i_req & ~bus.hlt;

`ifdef MEM_ARB_RR_EN
  // last_d=1 means data side owned the previous grant; reset as "I last granted"
  logic last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_d <= 1'b0;
    else if (grant) last_d <= pick_d;
  end

  assign pick_d = d_any & (~i_any | ~last_d);
`else
  assign pick_d = d_any;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (d_any | i_any) begin
          grant    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nx   = LAT_M1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          capture  = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner_d   <= 1'b0;
      is_wr     <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (grant) begin
        owner_d <= pick_d;
        // a simultaneous read+write request is handled as a write
        is_wr   <= pick_d & bus.d_we;
        addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
        wdata_q <= (pick_d & bus.d_we) ? bus.d_wdata : 16'h0000;
      end
      if (capture && !is_wr) begin
        if (owner_d) d_rdata_q <= bus.mem_rdata;
        else         i_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_re    = (state == ISSUE) & ~is_wr;
  assign bus.mem_we    = (state == ISSUE) &  is_wr;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdy     = (state == RESP) & ~owner_d;
  assign bus.d_rdy     = (state == RESP) &  owner_d;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (grant slots of LAT+3 cycles, shadow memory, priority rule).
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if ifc ();

  mem_arbiter #(.LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: data valid only exactly LAT cycles after the strobe cycle
  logic [15:0] mem_arr [256];
  bit          written [256];
  int          mcyc = 0;
  int          rd_due = -1;
  logic [7:0]  rd_addr = 8'h00;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return 16'hB123 + (a - 16'd4) * 16'h0101;
  endfunction

  always @(posedge clk) begin
    mcyc <= mcyc + 1;
    if (ifc.mem_re) begin
      rd_due  <= mcyc + LAT;
      rd_addr <= ifc.mem_addr[7:0];
    end
    if (ifc.mem_we) begin
      mem_arr[ifc.mem_addr[7:0]] <= ifc.mem_wdata;
      written[ifc.mem_addr[7:0]] <= 1'b1;
    end
  end

  always_comb begin
    ifc.mem_rdata = 16'hDEAD;
    if (mcyc == rd_due)
      ifc.mem_rdata = written[rd_addr] ? mem_arr[rd_addr] : init_val({8'h00, rd_addr});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.hlt = 1'b0; ifc.i_req = 1'b0; ifc.i_addr = 16'h0;
    ifc.d_re = 1'b0; ifc.d_we = 1'b0; ifc.d_addr = 16'h0; ifc.d_wdata = 16'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({ifc.i_rdy, ifc.d_rdy, ifc.mem_re, ifc.mem_we, ifc.busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=00000",
        {ifc.i_rdy, ifc.d_rdy, ifc.mem_re, ifc.mem_we, ifc.busy});
    end
    checks++;
    if ({ifc.i_rdata, ifc.d_rdata, ifc.mem_addr, ifc.mem_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_data got=%h want=0",
        {ifc.i_rdata, ifc.d_rdata, ifc.mem_addr, ifc.mem_wdata});
    end
    rst_n = 1'b1;
    step();
    ifc.i_req = 1'b1; ifc.i_addr = 16'h0010;
    step();
    checks++;
    if (ifc.mem_re !== 1'b1 || ifc.mem_addr !== 16'h0010) begin
      errors++; $display("FAIL reset_pre_issue got re=%b addr=%h want re=1 addr=0010", ifc.mem_re, ifc.mem_addr);
    end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.mem_re, ifc.mem_we, ifc.busy, ifc.i_rdy} !== 4'b0 || ifc.mem_addr !== 16'h0) begin
      errors++; $display("FAIL reset_mid_wait got re=%b we=%b busy=%b irdy=%b addr=%h want all 0",
        ifc.mem_re, ifc.mem_we, ifc.busy, ifc.i_rdy, ifc.mem_addr);
    end
    ifc.i_req = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (ifc.i_rdy !== 1'b0 || ifc.busy !== 1'b0) begin
        errors++; $display("FAIL reset_lost_access k=%0d got irdy=%b busy=%b want 0 0", k, ifc.i_rdy, ifc.busy);
      end
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    ifc.i_req = 1'b1; ifc.i_addr = 16'h0004;
    for (int k = 1; k <= LAT + 3; k++) begin
      step();
      checks++;
      if (ifc.mem_re !== (k == 1) || ifc.i_rdy !== (k == LAT + 2)) begin
        errors++; $display("FAIL fetch_timing k=%0d got re=%b irdy=%b want re=%b irdy=%b",
          k, ifc.mem_re, ifc.i_rdy, (k == 1), (k == LAT + 2));
      end
      if (k >= LAT + 2) begin
        checks++;
        if (ifc.i_rdata !== 16'hB123) begin
          errors++; $display("FAIL fetch_data k=%0d got=%h want=B123", k, ifc.i_rdata);
        end
        ifc.i_req = 1'b0;
      end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    ifc.d_we = 1'b1; ifc.d_addr = 16'h0020; ifc.d_wdata = 16'h5A5A;
    for (int k = 1; k <= 2 * LAT + 6; k++) begin
      step();
      checks++;
      if (ifc.d_rdy !== (k == LAT + 2 || k == 2 * LAT + 5)) begin
        errors++; $display("FAIL wr_rd_drdy k=%0d got=%b", k, ifc.d_rdy);
      end
      if (k == 1) begin
        checks++;
        if (ifc.mem_we !== 1'b1 || ifc.mem_re !== 1'b0 || ifc.mem_wdata !== 16'h5A5A || ifc.mem_addr !== 16'h0020) begin
          errors++; $display("FAIL wr_strobe got we=%b re=%b wdata=%h addr=%h want 1 0 5A5A 0020",
            ifc.mem_we, ifc.mem_re, ifc.mem_wdata, ifc.mem_addr);
        end
      end
      if (k == LAT + 2) begin
        checks++;
        if (ifc.d_rdata !== 16'h0000) begin
          errors++; $display("FAIL wr_rdata_unchanged got=%h want=0000", ifc.d_rdata);
        end
        ifc.d_we = 1'b0; ifc.d_re = 1'b1;
      end
      if (k == LAT + 4) begin
        checks++;
        if (ifc.mem_re !== 1'b1) begin
          errors++; $display("FAIL rd_strobe got=%b want=1", ifc.mem_re);
        end
      end
      if (k == 2 * LAT + 5) begin
        checks++;
        if (ifc.d_rdata !== 16'h5A5A) begin
          errors++; $display("FAIL rd_data got=%h want=5A5A", ifc.d_rdata);
        end
        ifc.d_re = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    ifc.i_req = 1'b1; ifc.i_addr = 16'h0004;
    ifc.d_re = 1'b1;  ifc.d_addr = 16'h0020;
    for (int k = 1; k <= 2 * LAT + 6; k++) begin
      step();
      checks++;
      if (ifc.d_rdy !== (k == LAT + 2) || ifc.i_rdy !== (k == 2 * LAT + 5)) begin
        errors++; $display("FAIL contention_rdy k=%0d got d=%b i=%b want d=%b i=%b",
          k, ifc.d_rdy, ifc.i_rdy, (k == LAT + 2), (k == 2 * LAT + 5));
      end
      if (k == LAT + 2) begin
        checks++;
        if (ifc.d_rdata !== 16'h5A5A) begin
          errors++; $display("FAIL contention_ddata got=%h want=5A5A", ifc.d_rdata);
        end
        ifc.d_re = 1'b0;
      end
      if (k == LAT + 4) begin
        checks++;
        if (ifc.mem_re !== 1'b1 || ifc.mem_addr !== 16'h0004) begin
          errors++; $display("FAIL contention_istrobe got re=%b addr=%h want 1 0004", ifc.mem_re, ifc.mem_addr);
        end
      end
      if (k == 2 * LAT + 5) begin
        checks++;
        if (ifc.i_rdata !== 16'hB123) begin
          errors++; $display("FAIL contention_idata got=%h want=B123", ifc.i_rdata);
        end
        ifc.i_req = 1'b0;
      end
    end
`ifdef MEM_ARB_RR_EN
    do_reset();
    ifc.i_req = 1'b1; ifc.d_re = 1'b1;
    for (int k = 1; k <= 4 * (LAT + 3); k++) begin
      step();
      if ((k % (LAT + 3)) == LAT + 2) begin
        checks++;
        if (ifc.d_rdy !== ((k / (LAT + 3)) % 2 == 0) || ifc.i_rdy !== ((k / (LAT + 3)) % 2 == 1)) begin
          errors++; $display("FAIL rr_alternate k=%0d got d=%b i=%b", k, ifc.d_rdy, ifc.i_rdy);
        end
      end
    end
    clear_inputs();
    step(); step();
`endif
  endtask

  task automatic test_halt();
    do_reset();
    ifc.hlt = 1'b1;
    ifc.i_req = 1'b1; ifc.i_addr = 16'h0008;
    ifc.d_re = 1'b1;  ifc.d_addr = 16'h0030;
    for (int k = 1; k <= LAT + 8; k++) begin
      step();
      checks++;
      if (ifc.i_rdy !== 1'b0 || ifc.d_rdy !== (k == LAT + 2)) begin
        errors++; $display("FAIL halt_rdy k=%0d got i=%b d=%b", k, ifc.i_rdy, ifc.d_rdy);
      end
      if (k == LAT + 2) begin
        checks++;
        if (ifc.d_rdata !== init_val(16'h0030)) begin
          errors++; $display("FAIL halt_ddata got=%h want=%h", ifc.d_rdata, init_val(16'h0030));
        end
        ifc.d_re = 1'b0;
      end
      if (k == LAT + 5) begin
        checks++;
        if (ifc.busy !== 1'b0) begin
          errors++; $display("FAIL halt_idle got busy=%b want=0", ifc.busy);
        end
      end
    end
    ifc.hlt = 1'b0;
    for (int j = 1; j <= LAT + 3; j++) begin
      step();
      checks++;
      if (ifc.i_rdy !== (j == LAT + 2)) begin
        errors++; $display("FAIL halt_release j=%0d got irdy=%b want=%b", j, ifc.i_rdy, (j == LAT + 2));
      end
      if (j == LAT + 2) begin
        checks++;
        if (ifc.i_rdata !== init_val(16'h0008)) begin
          errors++; $display("FAIL halt_idata got=%h want=%h", ifc.i_rdata, init_val(16'h0008));
        end
        ifc.i_req = 1'b0;
      end
    end
  endtask

  // Transaction-level model: each grant occupies LAT+3 cycles, rdy at grant+LAT+2.
  task automatic test_random();
    int          g = -100;
    int          resp = -100;
    bit          own_d = 1'b0, own_wr = 1'b0, last_d = 1'b0;
    bit          prev_i = 1'b0, prev_d = 1'b0;
    logic [15:0] pend = 16'h0, g_addr = 16'h0, g_wdata = 16'h0;
    logic [15:0] exp_ir = 16'h0, exp_dr = 16'h0;
    logic [15:0] mdl [16];
    do_reset();
    for (int a = 0; a < 16; a++) mdl[a] = init_val(16'(a));
    for (int c = 0; c < 1500; c++) begin
      bit ei, ed, dq, iq;
      int r;
      if (c == resp && !own_wr) begin
        if (own_d) exp_dr = pend;
        else       exp_ir = pend;
      end
      ei = (c == resp) && !own_d;
      ed = (c == resp) &&  own_d;
      checks++;
      if (ifc.i_rdy !== ei || ifc.d_rdy !== ed) begin
        errors++; $display("FAIL rnd_rdy c=%0d got i=%b d=%b want i=%b d=%b", c, ifc.i_rdy, ifc.d_rdy, ei, ed);
      end
      checks++;
      if (ifc.i_rdata !== exp_ir || ifc.d_rdata !== exp_dr) begin
        errors++; $display("FAIL rnd_rdata c=%0d got i=%h d=%h want i=%h d=%h", c, ifc.i_rdata, ifc.d_rdata, exp_ir, exp_dr);
      end
      checks++;
      if (ifc.busy !== (c > g && c < g + LAT + 3)) begin
        errors++; $display("FAIL rnd_busy c=%0d got=%b", c, ifc.busy);
      end
      checks++;
      if (ifc.mem_re !== (c == g + 1 && !own_wr) || ifc.mem_we !== (c == g + 1 && own_wr)) begin
        errors++; $display("FAIL rnd_strobe c=%0d got re=%b we=%b", c, ifc.mem_re, ifc.mem_we);
      end
      if (c > g && c <= g + LAT + 1) begin
        checks++;
        if (ifc.mem_addr !== g_addr || (own_wr && ifc.mem_wdata !== g_wdata)) begin
          errors++; $display("FAIL rnd_addr c=%0d got addr=%h wdata=%h want addr=%h wdata=%h",
            c, ifc.mem_addr, ifc.mem_wdata, g_addr, g_wdata);
        end
      end
      if (prev_i || !ifc.i_req) begin
        ifc.i_req  = ($urandom_range(0, 2) != 0);
        ifc.i_addr = 16'($urandom_range(0, 15));
      end
      if (prev_d || !(ifc.d_re || ifc.d_we)) begin
        r = $urandom_range(0, 3);
        ifc.d_re    = (r == 1 || r == 3);
        ifc.d_we    = (r == 2 || r == 3);
        ifc.d_addr  = 16'($urandom_range(0, 15));
        ifc.d_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) ifc.hlt = ~ifc.hlt;
      prev_i = ei;
      prev_d = ed;
      if (c >= g + LAT + 3) begin
        dq = ifc.d_re || ifc.d_we;
        iq = ifc.i_req && !ifc.hlt;
        if (dq || iq) begin
`ifdef MEM_ARB_RR_EN
          own_d = dq && (!iq || !last_d);
`else
          own_d = dq;
`endif
          last_d = own_d;
          g      = c;
          resp   = c + LAT + 2;
          own_wr = own_d && ifc.d_we;
          g_addr = own_d ? ifc.d_addr : ifc.i_addr;
          if (own_wr) begin
            g_wdata = ifc.d_wdata;
            mdl[ifc.d_addr[3:0]] = ifc.d_wdata;
          end else begin
            pend = mdl[g_addr[3:0]];
          end
        end
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write_read();
    test_contention();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
